// File: rtl/rd_arbiter.sv
// Shares one memory read port among n_req requesters, with one transaction outstanding at a time.
// Macro RD_ARB_RR_EN selects round-robin arbitration; when it is undefined, arbitration is fixed priority (index 0 highest).
module rd_arbiter #(
   parameter int unsigned addr_w = 5,
   parameter int unsigned data_w = 32,
   parameter int unsigned n_req  = 2
) (
   input  logic                    Clk,
   input  logic                    nRst,
   input  logic [n_req*addr_w-1:0] ReqAddr,
   input  logic [n_req-1:0]        ReqEnable,
   output logic [data_w-1:0]       ReqData,
   output logic [n_req-1:0]        ReqValid,
   output logic [addr_w-1:0]       MemAddr,
   output logic                    MemEnable,
   input  logic [data_w-1:0]       MemData,
   input  logic                    MemValid,
   output logic [n_req-1:0]        Grant,
   output logic                    Busy
);

   localparam int unsigned IDX_W = (n_req > 1) ? $clog2(n_req) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [n_req-1:0]    r_grant, w_grant_nxt, w_win_oh;
   logic                r_mem_en, w_mem_en_nxt, w_found;
   logic [addr_w-1:0]   r_mem_addr, w_mem_addr_nxt, w_win_addr;
`ifdef RD_ARB_RR_EN
   logic [IDX_W-1:0]    r_ptr, w_ptr_nxt, w_win_idx;
`endif

   // Winner select: an optional round-robin pass above the pointer, then a lowest-index pass.
   always_comb begin : win_sel
      w_found  = 1'b0;
      w_win_oh = '0;
`ifdef RD_ARB_RR_EN
      w_win_idx = '0;
      for (int unsigned i = 0; i < n_req; i++) begin
         if (!w_found && ReqEnable[i] && (IDX_W'(i) > r_ptr)) begin
            w_found     = 1'b1;
            w_win_oh[i] = 1'b1;
            w_win_idx   = IDX_W'(i);
         end
      end
`endif
      for (int unsigned i = 0; i < n_req; i++) begin
         if (!w_found && ReqEnable[i]) begin
            w_found     = 1'b1;
            w_win_oh[i] = 1'b1;
`ifdef RD_ARB_RR_EN
            w_win_idx   = IDX_W'(i);
`endif
         end
      end
   end

   // One-hot address mux driven by the winner.
   always_comb begin : addr_sel
      w_win_addr = '0;
      for (int unsigned i = 0; i < n_req; i++) begin
         w_win_addr = w_win_addr | (ReqAddr[i*addr_w +: addr_w] & {addr_w{w_win_oh[i]}});
      end
   end

   always_comb begin : fsm_nxt
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_mem_en_nxt   = r_mem_en;
      w_mem_addr_nxt = r_mem_addr;
`ifdef RD_ARB_RR_EN
      w_ptr_nxt      = r_ptr;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt    = S_BUSY;
               w_grant_nxt    = w_win_oh;
               w_mem_en_nxt   = 1'b1;
               w_mem_addr_nxt = w_win_addr;
`ifdef RD_ARB_RR_EN
               w_ptr_nxt      = w_win_idx;
`endif
            end else begin
               w_grant_nxt  = '0;
               w_mem_en_nxt = 1'b0;
            end
         end
         S_BUSY: begin
            if (MemValid) begin
               w_state_nxt  = S_IDLE;
               w_grant_nxt  = '0;
               w_mem_en_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_grant_nxt  = '0;
            w_mem_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge nRst) begin : fsm_reg
      if (!nRst) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
`ifdef RD_ARB_RR_EN
         r_ptr      <= IDX_W'(n_req - 1);
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_mem_en   <= w_mem_en_nxt;
         r_mem_addr <= w_mem_addr_nxt;
`ifdef RD_ARB_RR_EN
         r_ptr      <= w_ptr_nxt;
`endif
      end
   end

   // Responses route straight through; a MemValid arriving while idle is dropped.
   assign Busy      = (r_state == S_BUSY);
   assign Grant     = r_grant;
   assign MemEnable = r_mem_en;
   assign MemAddr   = r_mem_addr;
   assign ReqData   = MemData;
   assign ReqValid  = r_grant & {n_req{MemValid & Busy}};

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed bench for rd_arbiter: a scoreboard of expected requester responses, checked with immediate assertions.
`timescale 1ns/1ps
module tb_rd_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 2;

   logic             Clk = 1'b0;
   logic             nRst = 1'b0;
   logic [NR*AW-1:0] ReqAddr;
   logic [NR-1:0]    ReqEnable;
   logic [DW-1:0]    ReqData;
   logic [NR-1:0]    ReqValid;
   logic [AW-1:0]    MemAddr;
   logic             MemEnable;
   logic [DW-1:0]    MemData;
   logic             MemValid;
   logic [NR-1:0]    Grant;
   logic             Busy;
   logic             mv_drv;
   logic             tie_mode;

   typedef struct {
      logic [NR-1:0] vmask;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_asrt = 0;
   int   n_fail = 0;
   int   last_grant = NR - 1;

   assign MemValid = tie_mode ? MemEnable : mv_drv;

   rd_arbiter #(.addr_w(AW), .data_w(DW), .n_req(NR)) dut (
      .Clk       (Clk),
      .nRst      (nRst),
      .ReqAddr   (ReqAddr),
      .ReqEnable (ReqEnable),
      .ReqData   (ReqData),
      .ReqValid  (ReqValid),
      .MemAddr   (MemAddr),
      .MemEnable (MemEnable),
      .MemData   (MemData),
      .MemValid  (MemValid),
      .Grant     (Grant),
      .Busy      (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic int winner(input logic [NR-1:0] req);
`ifdef RD_ARB_RR_EN
      for (int k = 1; k <= int'(NR); k++) begin
         int j;
         j = (last_grant + k) % int'(NR);
         if (req[j]) return j;
      end
`else
      for (int j = 0; j < int'(NR); j++) begin
         if (req[j]) return j;
      end
`endif
      return -1;
   endfunction

   task automatic expect_grant(input string tag, input int w, input logic [AW-1:0] addr);
      chk({tag, "_grant"}, 32'(Grant), 32'(1) << w);
      chk({tag, "_memen"}, 32'(MemEnable), 32'(1));
      chk({tag, "_busy"}, 32'(Busy), 32'(1));
      chk({tag, "_memaddr"}, 32'(MemAddr), 32'(addr));
      last_grant = w;
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_asrt++;
         n_fail++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_rvalid"}, 32'(ReqValid), 32'(e.vmask));
         chk({tag, "_rdata"}, 32'(ReqData), 32'(e.data));
      end
   endtask

   task automatic mem_pulse(input string tag, input int w, input logic [DW-1:0] d);
      exp_t e;
      mv_drv   = 1'b1;
      MemData  = d;
      e.vmask  = NR'(1) << w;
      e.data   = d;
      sb.push_back(e);
      #1;
      sb_check(tag);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int w;
      exp_t e;
      ReqAddr   = '0;
      ReqEnable = '0;
      MemData   = '0;
      mv_drv    = 1'b0;
      tie_mode  = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_grant", 32'(Grant), 32'(0));
      chk("rst_memen", 32'(MemEnable), 32'(0));
      chk("rst_busy", 32'(Busy), 32'(0));
      chk("rst_memaddr", 32'(MemAddr), 32'(0));
      chk("rst_rvalid", 32'(ReqValid), 32'(0));
      nRst = 1'b1;
      step();

      // Reset while busy abandons the transaction
      ReqAddr[AW +: AW] = 5'h15;
      ReqEnable = 2'b10;
      w = winner(2'b10);
      step();
      expect_grant("rstmid_pre", w, 5'h15);
      ReqEnable = 2'b00;
      #2 nRst = 1'b0;
      #1;
      chk("rstmid_grant", 32'(Grant), 32'(0));
      chk("rstmid_memen", 32'(MemEnable), 32'(0));
      chk("rstmid_busy", 32'(Busy), 32'(0));
      last_grant = NR - 1;
      step();
      nRst    = 1'b1;
      mv_drv  = 1'b1;
      MemData = 32'h5555_5555;
      #1;
      chk("rstmid_spur_rvalid", 32'(ReqValid), 32'(0));
      step();
      mv_drv = 1'b0;
      chk("rstmid_post_busy", 32'(Busy), 32'(0));

      // Single request with a 3-cycle memory latency
      ReqAddr[0 +: AW] = 5'h0A;
      ReqEnable = 2'b01;
      w = winner(2'b01);
      step();
      expect_grant("single", w, 5'h0A);
      repeat (2) begin
         step();
         chk("single_wait_rvalid", 32'(ReqValid), 32'(0));
         chk("single_wait_busy", 32'(Busy), 32'(1));
      end
      step();
      mem_pulse("single", 0, 32'hDEAD_BEEF);
      ReqEnable = 2'b00;
      step();
      mv_drv = 1'b0;
      #1;
      chk("single_end_rvalid", 32'(ReqValid), 32'(0));
      chk("single_end_busy", 32'(Busy), 32'(0));
      chk("single_end_memen", 32'(MemEnable), 32'(0));
      chk("single_end_grant", 32'(Grant), 32'(0));

      // Contention: both requesters held high
      ReqAddr[0 +: AW]  = 5'h01;
      ReqAddr[AW +: AW] = 5'h12;
      ReqEnable = 2'b11;
      for (int t = 0; t < 4; t++) begin
         w = winner(2'b11);
         step();
         expect_grant("cont", w, (w == 1) ? 5'h12 : 5'h01);
         step();
         mem_pulse("cont", w, 32'hC0DE_0000 + 32'(t));
         step();
         mv_drv = 1'b0;
         #1;
         chk("cont_gap_memen", 32'(MemEnable), 32'(0));
         chk("cont_gap_grant", 32'(Grant), 32'(0));
      end
      ReqEnable = 2'b10;
      w = winner(2'b10);
      step();
      expect_grant("cont_req1", w, 5'h12);
      step();
      mem_pulse("cont_req1", w, 32'h0B0B_0B0B);
      ReqEnable = 2'b00;
      step();
      mv_drv = 1'b0;
      #1;
      chk("cont_end_busy", 32'(Busy), 32'(0));

      // Zero-latency memory: MemValid follows MemEnable
      ReqAddr[0 +: AW] = 5'h07;
      tie_mode  = 1'b1;
      ReqEnable = 2'b01;
      for (int t = 0; t < 3; t++) begin
         MemData = 32'hA000_0000 + 32'(t);
         w = winner(2'b01);
         step();
         expect_grant("zlat", w, 5'h07);
         e.vmask = NR'(1) << w;
         e.data  = 32'hA000_0000 + 32'(t);
         sb.push_back(e);
         sb_check("zlat");
         step();
         chk("zlat_idle_memen", 32'(MemEnable), 32'(0));
         chk("zlat_idle_busy", 32'(Busy), 32'(0));
         chk("zlat_idle_rvalid", 32'(ReqValid), 32'(0));
      end
      ReqEnable = 2'b00;
      step();
      tie_mode = 1'b0;

      // Spurious MemValid while idle
      mv_drv  = 1'b1;
      MemData = 32'h0000_0BAD;
      #1;
      chk("spur_rvalid", 32'(ReqValid), 32'(0));
      step();
      mv_drv = 1'b0;
      chk("spur_busy", 32'(Busy), 32'(0));
      chk("spur_memen", 32'(MemEnable), 32'(0));
      chk("spur_grant", 32'(Grant), 32'(0));
      chk("sb_empty", 32'(sb.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
